// File: rtl/hsi_pkg.sv
// Shared op codes, error codes and sequencer state encoding for the HSI vector path.
package hsi_pkg;

    localparam logic [3:0] OP_CROSS = 4'd1;
    localparam logic [3:0] OP_DOT   = 4'd2;

    localparam logic [3:0] ERR_NONE     = 4'd0;
    localparam logic [3:0] ERR_OP       = 4'd1;
    localparam logic [3:0] ERR_IN_EMPTY = 4'd2;
    localparam logic [3:0] ERR_OUT_FULL = 4'd3;
    localparam logic [3:0] ERR_BANDS    = 4'd4;
    localparam logic [3:0] ERR_TIMEOUT  = 4'd5;

    typedef enum logic [3:0] {
        IDLE, CHECK, PUSH, START, WAIT, READ, HOLD, DONE, ERR
    } state_t;

    // Band-count overflow takes precedence over an unsupported op/band combination.
    function automatic logic [3:0] cfg_check(input logic [3:0]  op,
                                             input logic [31:0] bands,
                                             input logic [31:0] max_bands);
        if (bands > max_bands)
            return ERR_BANDS;
        if ((op == OP_CROSS && bands == 32'd3) || (op == OP_DOT && bands != 32'd0))
            return ERR_NONE;
        return ERR_OP;
    endfunction

endpackage

// File: rtl/hsi_job_sequencer.sv
// Job sequencer: feeds one operand pair per pixel to the vector core and returns each result.
// Latency: per pixel PUSH, START, WAIT (core time), READ, HOLD; one pixel in flight at a time.
// Backpressure: sources stall on either core FIFO full; result held on res_data until res_ready.
module hsi_job_sequencer
    import hsi_pkg::*;
#(
    parameter int  COMPONENT_WIDTH = 16,
    parameter int  COMPONENTS_MAX  = 3,
    parameter int  TIMEOUT         = 64,
    localparam int VW              = COMPONENT_WIDTH * COMPONENTS_MAX
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [3:0]    cfg_op,
    input  logic [31:0]   cfg_bands,
    input  logic [15:0]   cfg_pixels,
    input  logic          src1_valid,
    output logic          src1_ready,
    input  logic [VW-1:0] src1_data,
    input  logic          src2_valid,
    output logic          src2_ready,
    input  logic [VW-1:0] src2_data,
    output logic          core_in1_wr_en,
    output logic [VW-1:0] core_in1_data,
    input  logic          core_in1_full,
    output logic          core_in2_wr_en,
    output logic [VW-1:0] core_in2_data,
    input  logic          core_in2_full,
    output logic [3:0]    core_op_code,
    output logic [31:0]   core_num_bands,
    output logic          core_start,
    input  logic [3:0]    core_error_code,
    input  logic          core_out_empty,
    output logic          core_out_rd_en,
    input  logic [VW-1:0] core_out_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [VW-1:0] res_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [3:0]    err_code,
    output logic [15:0]   pix_count,
    input  logic          err_clr
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t        state;
    logic [15:0]   remaining;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    cfg_err;
    logic          push;

    // Both sources and both core FIFOs must be ready, so no beat is ever taken alone.
    assign push = (state == PUSH) && src1_valid && src2_valid && !core_in1_full && !core_in2_full;

    assign src1_ready     = push;
    assign src2_ready     = push;
    assign core_in1_wr_en = push;
    assign core_in2_wr_en = push;
    assign core_in1_data  = src1_data;
    assign core_in2_data  = src2_data;
    assign cfg_ready      = (state == IDLE);
    assign busy           = (state != IDLE) && (state != ERR);
    assign cfg_err        = cfg_check(core_op_code, core_num_bands, 32'(COMPONENTS_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            remaining      <= '0;
            tmo_cnt        <= '0;
            core_op_code   <= '0;
            core_num_bands <= '0;
            core_start     <= 1'b0;
            core_out_rd_en <= 1'b0;
            res_valid      <= 1'b0;
            res_data       <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
            err_code       <= ERR_NONE;
            pix_count      <= '0;
        end else begin
            core_start     <= 1'b0;
            core_out_rd_en <= 1'b0;
            done           <= 1'b0;
            case (state)
                IDLE: if (cfg_valid) begin
                    core_op_code   <= cfg_op;
                    core_num_bands <= cfg_bands;
                    remaining      <= cfg_pixels;
                    pix_count      <= '0;
                    state          <= CHECK;
                end
                CHECK: begin
                    if (cfg_err != ERR_NONE) begin
                        err      <= 1'b1;
                        err_code <= cfg_err;
                        state    <= ERR;
                    end else if (remaining == 16'd0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= PUSH;
                    end
                end
                PUSH: if (push) begin
                    core_start <= 1'b1;
                    state      <= START;
                end
                START: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (core_error_code != ERR_NONE) begin
                        err      <= 1'b1;
                        err_code <= core_error_code;
                        state    <= ERR;
                    end else if (!core_out_empty) begin
                        core_out_rd_en <= 1'b1;
                        state          <= READ;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                READ: begin
                    res_data  <= core_out_data;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
                    pix_count <= pix_count + 16'd1;
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= PUSH;
                    end
                end
                DONE: state <= IDLE;
                ERR: if (err_clr) begin
                    err      <= 1'b0;
                    err_code <= ERR_NONE;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hsi_job_sequencer.sv
// Directed bench for hsi_job_sequencer with a small behavioural vector core and result scoreboard.
`timescale 1ns/1ps
module tb_hsi_job_sequencer;
    import hsi_pkg::*;

    localparam int CW  = 16;
    localparam int CM  = 3;
    localparam int TMO = 64;
    localparam int VW  = CW * CM;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid, cfg_ready;
    logic [3:0]    cfg_op;
    logic [31:0]   cfg_bands;
    logic [15:0]   cfg_pixels;
    logic          src1_valid, src1_ready, src2_valid, src2_ready;
    logic [VW-1:0] src1_data, src2_data;
    logic          core_in1_wr_en, core_in1_full, core_in2_wr_en, core_in2_full;
    logic [VW-1:0] core_in1_data, core_in2_data;
    logic [3:0]    core_op_code;
    logic [31:0]   core_num_bands;
    logic          core_start;
    logic [3:0]    core_error_code;
    logic          core_out_empty, core_out_rd_en;
    logic [VW-1:0] core_out_data;
    logic          res_valid, res_ready;
    logic [VW-1:0] res_data;
    logic          busy, done, err, err_clr;
    logic [3:0]    err_code;
    logic [15:0]   pix_count;

    always #5 clk = ~clk;

    hsi_job_sequencer #(.COMPONENT_WIDTH(CW), .COMPONENTS_MAX(CM), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
        .cfg_bands(cfg_bands), .cfg_pixels(cfg_pixels),
        .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_data(src1_data),
        .src2_valid(src2_valid), .src2_ready(src2_ready), .src2_data(src2_data),
        .core_in1_wr_en(core_in1_wr_en), .core_in1_data(core_in1_data), .core_in1_full(core_in1_full),
        .core_in2_wr_en(core_in2_wr_en), .core_in2_data(core_in2_data), .core_in2_full(core_in2_full),
        .core_op_code(core_op_code), .core_num_bands(core_num_bands), .core_start(core_start),
        .core_error_code(core_error_code), .core_out_empty(core_out_empty),
        .core_out_rd_en(core_out_rd_en), .core_out_data(core_out_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .pix_count(pix_count), .err_clr(err_clr)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [VW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [VW-1:0] vec(input int a, input int b, input int c);
        return {CW'(a), CW'(b), CW'(c)};
    endfunction

    function automatic logic [CW-1:0] cmp(input logic [VW-1:0] v, input int i);
        return v[(CM-1-i)*CW +: CW];
    endfunction

    function automatic logic [VW-1:0] core_calc(input logic [3:0] op, input logic [VW-1:0] a,
                                                input logic [VW-1:0] b);
        logic [CW-1:0] r0, r1, r2;
        if (op == OP_CROSS) begin
            r0 = cmp(a, 1) * cmp(b, 2) - cmp(a, 2) * cmp(b, 1);
            r1 = cmp(a, 2) * cmp(b, 0) - cmp(a, 0) * cmp(b, 2);
            r2 = cmp(a, 0) * cmp(b, 1) - cmp(a, 1) * cmp(b, 0);
        end else begin
            r0 = '0;
            r1 = '0;
            r2 = cmp(a, 0) * cmp(b, 0) + cmp(a, 1) * cmp(b, 1) + cmp(a, 2) * cmp(b, 2);
        end
        return {r0, r1, r2};
    endfunction

    // Behavioural core: result appears three cycles after start unless stalled.
    logic [VW-1:0] op1, op2, core_res;
    logic          out_vld;
    logic          core_stall = 1'b0;
    int            lat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            lat      <= 0;
            core_res <= '0;
            op1      <= '0;
            op2      <= '0;
        end else begin
            if (core_in1_wr_en) op1 <= core_in1_data;
            if (core_in2_wr_en) op2 <= core_in2_data;
            if (core_start && !core_stall) lat <= 3;
            else if (lat > 0) lat <= lat - 1;
            if (lat == 1) begin
                out_vld  <= 1'b1;
                core_res <= core_calc(core_op_code, op1, op2);
            end
            if (core_out_rd_en) out_vld <= 1'b0;
        end
    end
    assign core_out_empty = !out_vld;
    assign core_out_data  = core_res;

    int start_cnt = 0, rd_cnt = 0, wr1_cnt = 0, wr2_cnt = 0, done_cnt = 0, s1_cnt = 0, s2_cnt = 0;

    always @(negedge clk) begin
        if (core_start)                start_cnt++;
        if (core_out_rd_en)            rd_cnt++;
        if (core_in1_wr_en)            wr1_cnt++;
        if (core_in2_wr_en)            wr2_cnt++;
        if (done)                      done_cnt++;
        if (src1_valid && src1_ready)  s1_cnt++;
        if (src2_valid && src2_ready)  s2_cnt++;
        if (res_valid && res_ready) begin
            check("res_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("res_data", 64'(res_data), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [3:0] op, input logic [31:0] bands, input logic [15:0] pix);
        bit ok = 0;
        cfg_op = op; cfg_bands = bands; cfg_pixels = pix; cfg_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = cfg_ready;
        end
        tick();
        cfg_valid = 1'b0;
        check("cfg_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_push();
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = src1_ready;
        end
        tick();
        src1_valid = 1'b0; src2_valid = 1'b0;
        check("src_pushed", 64'(ok), 64'd1);
    endtask

    task automatic send_pair(input logic [VW-1:0] a, input logic [VW-1:0] b);
        src1_data = a; src2_data = b; src1_valid = 1'b1; src2_valid = 1'b1;
        wait_push();
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = done;
        end
        check("done_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_err();
        bit ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = err;
        end
        check("err_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_start();
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = core_start;
        end
        check("start_seen", 64'(ok), 64'd1);
    endtask

    task automatic clear_err();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err", 64'(err), 64'd0);
        check("clr_err_code", 64'(err_code), 64'd0);
        check("clr_cfg_ready", 64'(cfg_ready), 64'd1);
    endtask

    initial begin
        int s0, r0, w0, d0, n;
        bit stable;
        logic [VW-1:0] held;

        cfg_valid = 0; cfg_op = 0; cfg_bands = 0; cfg_pixels = 0;
        src1_valid = 0; src2_valid = 0; src1_data = '0; src2_data = '0;
        core_in1_full = 0; core_in2_full = 0; core_error_code = 0;
        res_ready = 1; err_clr = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_strobes", 64'({done, err, res_valid, core_start, core_out_rd_en, core_in1_wr_en}), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_pix_count", 64'(pix_count), 64'd0);
        check("rst_core_cfg", 64'({core_op_code, core_num_bands}), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Two-pixel dot product job
        d0 = done_cnt;
        exp_q.push_back(vec(0, 0, 6));
        exp_q.push_back(vec(0, 0, 30));
        do_cfg(OP_DOT, 3, 2);
        send_pair(vec(1, 2, 3), vec(1, 1, 1));
        send_pair(vec(4, 5, 6), vec(2, 2, 2));
        wait_done();
        check("dot_pix_count", 64'(pix_count), 64'd2);
        tick();
        check("dot_done_pulse", 64'(done), 64'd0);
        check("dot_done_count", 64'(done_cnt - d0), 64'd1);
        check("dot_drained", 64'(exp_q.size()), 64'd0);
        check("dot_pix_hold", 64'(pix_count), 64'd2);

        // Single cross product
        s0 = start_cnt; r0 = rd_cnt;
        exp_q.push_back(vec(0, 0, 1));
        do_cfg(OP_CROSS, 3, 1);
        check("cfg_clears_pix", 64'(pix_count), 64'd0);
        send_pair(vec(1, 0, 0), vec(0, 1, 0));
        wait_done();
        tick();
        check("cross_starts", 64'(start_cnt - s0), 64'd1);
        check("cross_reads", 64'(rd_cnt - r0), 64'd1);
        check("cross_drained", 64'(exp_q.size()), 64'd0);
        check("cross_pix_count", 64'(pix_count), 64'd1);

        // Zero-pixel job completes without touching the core
        w0 = wr1_cnt;
        do_cfg(OP_DOT, 3, 0);
        wait_done();
        tick();
        check("zero_pix_no_wr", 64'(wr1_cnt - w0), 64'd0);

        // Unsupported op/bands and band overflow
        w0 = wr1_cnt;
        do_cfg(OP_CROSS, 2, 5);
        wait_err();
        check("op_err_code", 64'(err_code), 64'(ERR_OP));
        check("err_not_busy", 64'(busy), 64'd0);
        check("err_cfg_ready", 64'(cfg_ready), 64'd0);
        check("op_err_no_wr", 64'(wr1_cnt - w0), 64'd0);
        clear_err();
        do_cfg(OP_DOT, 4, 1);
        wait_err();
        check("bands_err_code", 64'(err_code), 64'(ERR_BANDS));
        clear_err();

        // Core never produces: timeout; err rises TIMEOUT cycles after the START cycle ends
        core_stall = 1'b1;
        r0 = rd_cnt;
        do_cfg(OP_DOT, 3, 1);
        src1_data = vec(1, 1, 1); src2_data = vec(1, 1, 1); src1_valid = 1; src2_valid = 1;
        wait_start();
        src1_valid = 0; src2_valid = 0;
        n = 0;
        for (int i = 0; i < TMO + 20 && !err; i++) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 64'(n), 64'(TMO + 1));
        check("timeout_code", 64'(err_code), 64'(ERR_TIMEOUT));
        check("timeout_no_rd", 64'(rd_cnt - r0), 64'd0);
        clear_err();

        // Core reports an error during WAIT; code is sticky
        do_cfg(OP_DOT, 3, 1);
        send_pair(vec(1, 1, 1), vec(1, 1, 1));
        tick();
        core_error_code = ERR_OUT_FULL;
        wait_err();
        check("core_err_code", 64'(err_code), 64'(ERR_OUT_FULL));
        tick();
        core_error_code = ERR_NONE;
        tick();
        check("core_err_sticky", 64'(err_code), 64'(ERR_OUT_FULL));
        clear_err();
        core_stall = 1'b0;

        // Result backpressure, ignored cfg, single-source and FIFO-full stalls
        res_ready = 1'b0;
        exp_q.push_back(vec(0, 0, 6));
        exp_q.push_back(vec(0, 0, 30));
        do_cfg(OP_DOT, 3, 2);
        send_pair(vec(1, 2, 3), vec(1, 1, 1));
        stable = 0;
        for (int i = 0; i < 100 && !stable; i++) begin
            @(negedge clk);
            stable = res_valid;
        end
        check("hold_res_valid", 64'(stable), 64'd1);
        held = res_data;
        tick();
        s0 = s1_cnt + s2_cnt;
        src1_data = vec(4, 5, 6); src2_data = vec(2, 2, 2); src1_valid = 1; src2_valid = 1;
        cfg_op = OP_CROSS; cfg_bands = 2; cfg_pixels = 9; cfg_valid = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(res_valid && res_data === held)) stable = 0;
        end
        check("hold_stable", 64'(stable), 64'd1);
        check("hold_no_consume", 64'(s1_cnt + s2_cnt - s0), 64'd0);
        check("cfg_ignored_op", 64'(core_op_code), 64'(OP_DOT));
        tick();
        cfg_valid = 0;
        src2_valid = 0;
        res_ready = 1'b1;
        w0 = wr1_cnt + wr2_cnt;
        repeat (10) tick();
        check("src1_only_no_consume", 64'(s1_cnt + s2_cnt - s0), 64'd0);
        check("src1_only_no_wr", 64'(wr1_cnt + wr2_cnt - w0), 64'd0);
        core_in1_full = 1'b1;
        src2_valid = 1'b1;
        repeat (5) tick();
        check("full_no_consume", 64'(s1_cnt + s2_cnt - s0), 64'd0);
        core_in1_full = 1'b0;
        wait_push();
        wait_done();
        check("bp_pix_count", 64'(pix_count), 64'd2);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // Reset during WAIT abandons the job
        core_stall = 1'b1;
        do_cfg(OP_DOT, 3, 1);
        send_pair(vec(1, 1, 1), vec(2, 2, 2));
        tick();
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_idle", 64'({cfg_ready, busy}), 64'b10);
        check("mid_rst_strobes", 64'({done, err, res_valid, core_start, core_out_rd_en}), 64'd0);
        check("mid_rst_core_cfg", 64'({core_op_code, core_num_bands}), 64'd0);
        check("mid_rst_pix", 64'(pix_count), 64'd0);
        w0 = wr1_cnt;
        tick();
        rst_n = 1'b1;
        core_stall = 1'b0;
        tick();
        exp_q.push_back(vec(0, 0, 21));
        do_cfg(OP_DOT, 3, 1);
        send_pair(vec(0, 0, 7), vec(0, 0, 3));
        wait_done();
        check("post_rst_pix", 64'(pix_count), 64'd1);
        check("post_rst_writes", 64'(wr1_cnt - w0), 64'd1);
        check("post_rst_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hsi_job_sequencer.md
HSI_JOB_SEQUENCER -- requirements
Module: hsi_job_sequencer

Interface
REQ-001 SHALL have parameter COMPONENT_WIDTH, default 16, bits per H/S/I component.
REQ-002 SHALL have parameter COMPONENTS_MAX, default 3, maximum bands per vector; VW = COMPONENT_WIDTH*COMPONENTS_MAX.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles per pixel.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low
- cfg_valid in 1, cfg_ready out 1  job descriptor handshake
- cfg_op in 4, cfg_bands in 32, cfg_pixels in 16  operation, band count, pixel count
- src1_valid in 1, src1_ready out 1, src1_data in VW  operand stream 1
- src2_valid in 1, src2_ready out 1, src2_data in VW  operand stream 2
- core_in1_wr_en out 1, core_in1_data out VW, core_in1_full in 1  core input FIFO 1
- core_in2_wr_en out 1, core_in2_data out VW, core_in2_full in 1  core input FIFO 2
- core_op_code out 4, core_num_bands out 32, core_start out 1  core control
- core_error_code in 4, core_out_empty in 1, core_out_rd_en out 1, core_out_data in VW  core status/output
- res_valid out 1, res_ready in 1, res_data out VW  result stream
- busy out 1, done out 1 (pulse), err out 1, err_code out 4, pix_count out 16
- err_clr in 1  clears sticky error

Function
REQ-005 FSM states: IDLE, CHECK, PUSH, START, WAIT, READ, HOLD, DONE, ERR.
REQ-006 IDLE: cfg_ready=1; on cfg_valid, latch op/bands/pixels into core_op_code/core_num_bands/remaining counter, go CHECK.
REQ-007 CHECK: bands>COMPONENTS_MAX -> ERR code 4; op not (1 with bands==3) nor (2 with bands>0) -> ERR code 1; pixels==0 -> DONE; else PUSH.
REQ-008 PUSH: src1_ready=src2_ready=1 only when src1_valid & src2_valid & !core_in1_full & !core_in2_full; that cycle both wr_en=1 with src data passed through combinationally, go START.
REQ-009 START: core_start=1 for exactly one cycle, then WAIT; timeout counter cleared.
REQ-010 WAIT: core_error_code!=0 -> ERR with err_code=core_error_code; else !core_out_empty -> READ; else counter==TIMEOUT-1 -> ERR code 5.
REQ-011 READ: core_out_rd_en=1 one cycle; core_out_data registered into res_data the following cycle; then HOLD.
REQ-012 HOLD: res_valid=1, res_data stable until res_ready; on handshake pix_count+1, remaining-1; remaining reaches 0 -> DONE else PUSH.
REQ-013 DONE: done=1 for one cycle, then IDLE; pix_count holds until next accepted cfg (cleared on acceptance).
REQ-014 ERR: err=1, err_code sticky, core_start/wr_en/rd_en=0; err_clr -> IDLE with err_code=0.
REQ-015 busy=1 in every state except IDLE and ERR; cfg_ready=0 outside IDLE.
REQ-016 At most one pixel in flight in the core; a src beat is never consumed unless both sources are consumed that cycle.
REQ-017 err_clr outside ERR SHALL be ignored; cfg_valid outside IDLE SHALL be ignored.

Reset
REQ-018 rst_n low SHALL force IDLE, all strobes/valids/done/err=0, err_code=0, pix_count=0, counters=0, core_op_code=0, core_num_bands=0, res_data=0.
REQ-019 Reset mid-job SHALL abandon the job with no further core writes; pending core contents are the parent's concern.

Structure
REQ-020 Op codes (CROSS=1, DOT=2), error codes (NONE=0, OP=1, IN_EMPTY=2, OUT_FULL=3, BANDS=4, TIMEOUT=5) and the state enum SHALL live in shared package hsi_pkg.
REQ-021 No sub-module; the vector core is instantiated by the parent alongside this block.

Verification
REQ-022 cfg op=2, bands=3, pixels=2, src1={1,2,3},{4,5,6}, src2={1,1,1},{2,2,2}, model core -> two results dot 6 then 30, done pulse, pix_count=2.
REQ-023 cfg op=1, bands=3, pixels=1, src1={1,0,0}, src2={0,1,0} -> res_data {0,0,1}, one core_start pulse, one core_out_rd_en pulse.
REQ-024 cfg op=1, bands=2 -> ERR, err_code=1, no core wr_en; err_clr -> IDLE, cfg_ready=1.
REQ-025 core never deasserts core_out_empty -> err_code=5 exactly TIMEOUT cycles after START; core_error_code=3 during WAIT -> err_code=3.
REQ-026 res_ready low 10 cycles in HOLD -> res_data stable, no src consumption; only src1_valid high -> no push.
REQ-027 rst_n asserted during WAIT -> all outputs to reset values next edge; new cfg accepted after release.
